// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fifo_stream_pkg
//  Description : Shared types and helpers for the FIFO stream reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_stream_pkg;

  // Drain-control FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Width of a counter able to hold values 0..beats
  function automatic int cnt_width(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid2.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid2
//  Description : Two-entry in-order buffer. Unconditional write port, valid/
//                ready read port and an occupancy output for credit logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [1:0]            o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;
  logic                  w_pop;

  assign o_rd_valid = (r_occ != 2'd0);
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_occ      = r_occ;
  assign w_pop      = o_rd_valid && i_rd_ready;

  // Storage, pointers and occupancy; the writer guarantees no write when full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, i_wr_en} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Drains a 1-cycle-latency FIFO into a valid/ready stream with
//                a generated last flag every PKT_LEN beats. Stops requested
//                through enable are only taken on packet boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  PKT_LEN    = 16,
  localparam int CNT_WIDTH  = cnt_width(PKT_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] c_LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] c_ZERO      = '0;
  localparam logic [CNT_WIDTH-1:0] c_ONE       = CNT_WIDTH'(1);

  state_e               r_state;
  state_e               w_next_state;
  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_iss_cnt;
  logic [CNT_WIDTH-1:0] r_pop_cnt;
  logic                 w_issue_ok;
  logic                 w_pop;
  logic [1:0]           w_occ;
  logic [2:0]           w_pending;
  logic                 w_credit_ok;
  logic                 w_pkt_open;

  stream_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (reset),
    .i_wr_en    (r_inflight),
    .i_wr_data  (fifo_dout),
    .o_rd_valid (m_valid),
    .i_rd_ready (m_ready),
    .o_rd_data  (m_data),
    .o_occ      (w_occ)
  );

  assign w_pop      = m_valid && m_ready;
  assign w_pkt_open = (r_iss_cnt != c_ZERO);

  // Words that will sit in the buffer next cycle if nothing new is issued
  assign w_pending   = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit_ok = (w_pending < 3'd2);
  assign fifo_rd_en  = !reset && w_issue_ok && !fifo_empty && w_credit_ok;

  assign m_last = m_valid && (r_pop_cnt == c_LAST_BEAT);
  assign busy   = (r_state != IDLE) || r_inflight || (w_occ != 2'd0);

  // Read-in-flight flag and issue/pop beat counters, each wrapping per packet
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_iss_cnt  <= c_ZERO;
      r_pop_cnt  <= c_ZERO;
    end else begin
      r_inflight <= fifo_rd_en;
      if (fifo_rd_en) begin
        r_iss_cnt <= (r_iss_cnt == c_LAST_BEAT) ? c_ZERO : r_iss_cnt + c_ONE;
      end
      if (w_pop) begin
        r_pop_cnt <= (r_pop_cnt == c_LAST_BEAT) ? c_ZERO : r_pop_cnt + c_ONE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: a stop is taken at once on a boundary, else via FLUSH
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (enable) w_next_state = RUN;
      end
      RUN: begin
        if (!enable) w_next_state = w_pkt_open ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (enable)           w_next_state = RUN;
        else if (!w_pkt_open) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: a new packet is never opened in the cycle a stop is taken
  always_comb begin
    w_issue_ok = 1'b0;
    unique case (r_state)
      IDLE:    w_issue_ok = 1'b0;
      RUN:     w_issue_ok = enable || w_pkt_open;
      FLUSH:   w_issue_ok = w_pkt_open;
      default: w_issue_ok = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`timescale 1ns/1ps
// ============================================================================
//  Testbench   : tb_fifo_stream_reader
//  Description : Scoreboard bench with a FIFO model, random backpressure and
//                a second instance built with a one-beat packet length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int PL = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  logic          b_enable;
  logic          b_empty;
  logic [DW-1:0] b_dout;
  logic          b_rd_en;
  logic          b_valid;
  logic          b_ready;
  logic [DW-1:0] b_data;
  logic          b_last;
  logic          b_busy;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy));

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(b_enable), .fifo_empty(b_empty),
    .fifo_dout(b_dout), .fifo_rd_en(b_rd_en), .m_valid(b_valid),
    .m_ready(b_ready), .m_data(b_data), .m_last(b_last), .busy(b_busy));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO models (1-cycle read latency) ----------------
  logic [DW-1:0] fmem [0:1023];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (reset) begin
      rp        <= 0;
      fifo_dout <= '0;
    end else if (fifo_rd_en) begin
      fifo_dout <= fmem[rp];
      rp        <= rp + 1;
    end
  end

  logic [DW-1:0] bmem [0:7];
  int bwp = 0;
  int brp = 0;
  assign b_empty = (bwp == brp);

  always @(posedge clk) begin
    if (reset) begin
      brp    <= 0;
      b_dout <= '0;
    end else if (b_rd_en) begin
      b_dout <= bmem[brp];
      brp    <= brp + 1;
    end
  end

  // ---------------- Scoreboard ----------------
  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] bexpq[$];
  int            push_idx = 0;

  // A stream beat's last flag follows purely from its position since reset
  task automatic push_word(input logic [DW-1:0] d);
    exp_t e;
    fmem[wp] = d;
    wp       = wp + 1;
    e.d      = d;
    e.l      = ((push_idx % PL) == PL - 1);
    expq.push_back(e);
    push_idx++;
  endtask

  task automatic b_push(input logic [DW-1:0] d);
    bmem[bwp] = d;
    bwp       = bwp + 1;
    bexpq.push_back(d);
  endtask

  int            cyc = 0;
  int            n_pops = 0;
  int            n_reads = 0;
  int            outstanding = 0;
  int            first_pop_cyc = -1;
  int            last_pop_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  exp_t          mon_e;

  // Monitor for the PKT_LEN=16 instance
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        check("rd_en_while_empty", fifo_empty, 1'b0);
        n_reads++;
        outstanding++;
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (!m_valid) check("last_unqualified", m_last, 1'b0);
      if (m_valid && m_ready) begin
        check("beat_expected", expq.size() > 0, 1'b1);
        if (expq.size() > 0) begin
          mon_e = expq.pop_front();
          check("beat_data", m_data, mon_e.d);
          check("beat_last", m_last, mon_e.l);
        end
        n_pops++;
        outstanding--;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      check("outstanding_le_2", outstanding <= 2, 1'b1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  int            b_reads = 0;
  int            b_pops = 0;
  logic [DW-1:0] b_e;

  // Monitor for the PKT_LEN=1 instance
  always @(negedge clk) begin
    if (!reset) begin
      if (b_rd_en) begin
        check("b_rd_en_while_empty", b_empty, 1'b0);
        b_reads++;
      end
      if (b_valid && b_ready) begin
        check("b_beat_expected", bexpq.size() > 0, 1'b1);
        if (bexpq.size() > 0) begin
          b_e = bexpq.pop_front();
          check("b_beat_data", b_data, b_e);
        end
        check("b_beat_last", b_last, 1'b1);
        b_pops++;
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name, input int bound);
    int k = 0;
    while (expq.size() != 0 && k < bound) begin
      tick(1);
      k++;
    end
    check(name, expq.size(), 0);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (busy && k < bound) begin
      tick(1);
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic drain_and_stop(input string name);
    enable  = 1'b1;
    m_ready = 1'b1;
    wait_empty({name, "_drain"}, 400);
    enable = 1'b0;
    wait_idle({name, "_idle"}, 50);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rd_en"}, fifo_rd_en, 1'b0);
    check({name, "_valid"}, m_valid, 1'b0);
    check({name, "_last"}, m_last, 1'b0);
    check({name, "_data"}, m_data, '0);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    int   base_pops;
    int   base_reads;
    int   k;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset    = 1'b1;
    enable   = 1'b0;
    m_ready  = 1'b0;
    b_enable = 1'b0;
    b_ready  = 1'b0;
    tick(3);
    check_reset_outputs("por");
    check("por_b_busy", b_busy, 1'b0);
    reset = 1'b0;
    tick(1);

    // Streaming at full rate, latency of the first beat
    for (int i = 0; i < 32; i++) push_word(DW'(i));
    m_ready       = 1'b1;
    base_pops     = n_pops;
    first_pop_cyc = -1;
    enable        = 1'b1;
    check("lat_c0_rd_en", fifo_rd_en, 1'b0);
    tick(1);
    check("lat_c1_rd_en", fifo_rd_en, 1'b1);
    check("lat_c1_valid", m_valid, 1'b0);
    tick(1);
    check("lat_c2_valid", m_valid, 1'b0);
    tick(1);
    check("lat_c3_valid", m_valid, 1'b1);
    check("lat_c3_data", m_data, 0);
    wait_empty("t1_drain", 100);
    check("t1_beats", n_pops - base_pops, 32);
    check("t1_back_to_back", last_pop_cyc - first_pop_cyc, 31);
    enable = 1'b0;
    wait_idle("t1_idle", 20);

    // Periodic backpressure 1-0-0-1
    for (int i = 0; i < 32; i++) push_word(DW'(100 + i));
    base_pops = n_pops;
    enable    = 1'b1;
    k         = 0;
    while (expq.size() != 0 && k < 400) begin
      m_ready = pat[k % 4];
      tick(1);
      k++;
    end
    check("t2_drain", expq.size(), 0);
    check("t2_beats", n_pops - base_pops, 32);
    m_ready = 1'b1;
    enable  = 1'b0;
    wait_idle("t2_idle", 20);

    // Stop request mid-packet completes the packet, then halts
    for (int i = 0; i < 32; i++) push_word($urandom);
    base_pops  = n_pops;
    base_reads = n_reads;
    enable     = 1'b1;
    k          = 0;
    while ((n_reads - base_reads) < 5 && k < 100) begin
      m_ready = ($urandom_range(0, 1) == 1);
      tick(1);
      k++;
    end
    check("t3_reached_issue5", n_reads - base_reads, 5);
    enable = 1'b0;
    k      = 0;
    while (busy && k < 300) begin
      m_ready = ($urandom_range(0, 1) == 1);
      tick(1);
      k++;
    end
    check("t3_busy_falls", busy, 1'b0);
    check("t3_beats", n_pops - base_pops, 16);
    check("t3_reads", n_reads - base_reads, 16);
    check("t3_fifo_left", wp - rp, 16);
    tick(10);
    check("t3_no_more_reads", n_reads - base_reads, 16);
    check("t3_still_idle", busy, 1'b0);
    drain_and_stop("t3");

    // FIFO underrun mid-packet, refill later
    base_pops = n_pops;
    for (int i = 0; i < 7; i++) push_word(DW'(200 + i));
    m_ready = 1'b1;
    enable  = 1'b1;
    k       = 0;
    while (wp != rp && k < 50) begin
      tick(1);
      k++;
    end
    tick(10);
    check("t4_gap_beats", n_pops - base_pops, 7);
    check("t4_gap_busy", busy, 1'b1);
    for (int i = 7; i < 16; i++) push_word(DW'(200 + i));
    wait_empty("t4_drain", 100);
    check("t4_beats", n_pops - base_pops, 16);
    enable = 1'b0;
    wait_idle("t4_idle", 20);

    // Reset while holding buffered words
    for (int i = 0; i < 32; i++) push_word(DW'(300 + i));
    m_ready = 1'b0;
    enable  = 1'b1;
    tick(8);
    check("t5_holding", m_valid, 1'b1);
    reset  = 1'b1;
    enable = 1'b0;
    expq.delete();
    push_idx = 0;
    wp       = 0;
    tick(1);
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    for (int i = 0; i < 16; i++) push_word(DW'(32'hA0 + i));
    base_pops = n_pops;
    drain_and_stop("t5");
    check("t5_beats", n_pops - base_pops, 16);

    // Random soak: random pushes, backpressure and enable toggling
    base_pops = n_pops;
    k         = push_idx;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) push_word($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      tick(1);
    end
    while ((push_idx % PL) != 0) push_word($urandom);
    drain_and_stop("t6");
    check("t6_beats", n_pops - base_pops, push_idx - k);

    // One-beat packets: every beat last, stop is immediate
    for (int i = 0; i < 4; i++) b_push(DW'(32'h50 + i));
    b_ready  = 1'b1;
    b_enable = 1'b1;
    k        = 0;
    while (b_reads < 2 && k < 50) begin
      tick(1);
      k++;
    end
    b_enable = 1'b0;
    tick(10);
    check("t7_reads_after_stop", b_reads, 2);
    check("t7_pops_after_stop", b_pops, 2);
    check("t7_fifo_left", bwp - brp, 2);
    check("t7_busy", b_busy, 1'b0);
    b_enable = 1'b1;
    k        = 0;
    while (bexpq.size() != 0 && k < 50) begin
      tick(1);
      k++;
    end
    check("t7_drain", bexpq.size(), 0);
    check("t7_pops", b_pops, 4);
    b_enable = 1'b0;
    tick(5);
    check("t7_idle", b_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
